// File: rtl/video_timing_pkg.sv
// ---------------------------------------------------------------------------
// video_timing_pkg
// Shared definitions for the raster timing controller:
//   - vtg_state_e : controller state (IDLE / RUN / DRAIN)
//   - DEF_*       : default 640x480@60 timing constants
//   - axis_total  : total length of one axis (active + porches + sync)
// ---------------------------------------------------------------------------
package video_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vtg_state_e;

    localparam int unsigned DEF_H_ACTIVE = 32'd640;
    localparam int unsigned DEF_H_FP     = 32'd16;
    localparam int unsigned DEF_H_SYNC   = 32'd96;
    localparam int unsigned DEF_H_BP     = 32'd48;
    localparam int unsigned DEF_V_ACTIVE = 32'd480;
    localparam int unsigned DEF_V_FP     = 32'd10;
    localparam int unsigned DEF_V_SYNC   = 32'd2;
    localparam int unsigned DEF_V_BP     = 32'd33;

    // Total pixels (or lines) of one axis.
    function automatic int unsigned axis_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_axis_timing_decode.sv
// ---------------------------------------------------------------------------
// axis_timing_decode
// One raster axis: position counter plus region decode. The region flags
// are decoded from the *next* count so the parent can register them in the
// same edge as the counter and keep every output aligned to one pixel.
// Ports:
//   clk, rstn     pixel clock, async active-low reset
//   i_clear       force the counter to 0 (takes priority over advance)
//   i_advance     step the counter, wrapping TOTAL-1 -> 0
//   o_cnt         current (registered) position
//   o_last        current position is TOTAL-1
//   o_nxt_active  next position lies in the active region
//   o_nxt_sync    next position lies in the sync region
//   o_nxt_zero    next position is 0
//   o_nxt_last    next position is TOTAL-1
// ---------------------------------------------------------------------------
module axis_timing_decode
    import video_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP,
    parameter int unsigned LEN    = $clog2(axis_total(ACTIVE, FP, SYNC, BP))
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           i_clear,
    input  logic           i_advance,
    output logic [LEN-1:0] o_cnt,
    output logic           o_last,
    output logic           o_nxt_active,
    output logic           o_nxt_sync,
    output logic           o_nxt_zero,
    output logic           o_nxt_last
);

    localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [LEN-1:0] C_ZERO      = LEN'(32'd0);
    localparam logic [LEN-1:0] C_ONE       = LEN'(32'd1);
    localparam logic [LEN-1:0] C_LAST      = LEN'(TOTAL - 32'd1);
    localparam logic [LEN-1:0] C_ACTIVE    = LEN'(ACTIVE);
    localparam logic [LEN-1:0] C_SYNC_BEG  = LEN'(ACTIVE + FP);
    localparam logic [LEN-1:0] C_SYNC_END  = LEN'(ACTIVE + FP + SYNC - 32'd1);

    logic [LEN-1:0] r_cnt;
    logic [LEN-1:0] w_next;

    // Next position: clear wins, otherwise step with wrap at the last position.
    always_comb begin
        w_next = r_cnt;
        if (i_clear) begin
            w_next = C_ZERO;
        end else if (i_advance) begin
            if (r_cnt == C_LAST) begin
                w_next = C_ZERO;
            end else begin
                w_next = r_cnt + C_ONE;
            end
        end else begin
            w_next = r_cnt;
        end
    end

    // Position register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= C_ZERO;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign o_cnt        = r_cnt;
    assign o_last       = (r_cnt == C_LAST);
    assign o_nxt_active = (w_next < C_ACTIVE);
    assign o_nxt_sync   = (w_next >= C_SYNC_BEG) && (w_next <= C_SYNC_END);
    assign o_nxt_zero   = (w_next == C_ZERO);
    assign o_nxt_last   = (w_next == C_LAST);

endmodule

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
// Raster timing controller: sequences x/y through active, front porch, sync
// and back porch, with clean frame-boundary start/stop controlled by
// i_enable. All outputs are registered and describe the same pixel.
// Ports:
//   clk            pixel clock
//   rstn           asynchronous active-low reset
//   i_enable       run request, sampled every cycle
//   o_hsync        horizontal sync (HSYNC_POL when asserted)
//   o_vsync        vertical sync (VSYNC_POL when asserted)
//   o_de           data enable, active pixels only
//   o_x, o_y       current pixel coordinates
//   o_frame_start  pulse at (0,0)
//   o_frame_end    pulse at (H_TOTAL-1, V_TOTAL-1)
//   o_line_start   pulse at x = 0 while running
//   o_running      high in RUN or DRAIN
// ---------------------------------------------------------------------------
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned HLEN      = $clog2(axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    parameter int unsigned VLEN      = $clog2(axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_enable,
    output logic            o_hsync,
    output logic            o_vsync,
    output logic            o_de,
    output logic [HLEN-1:0] o_x,
    output logic [VLEN-1:0] o_y,
    output logic            o_frame_start,
    output logic            o_frame_end,
    output logic            o_line_start,
    output logic            o_running
);

    generate
        if ((H_ACTIVE < 32'd1) || (H_FP < 32'd1) || (H_SYNC < 32'd1) || (H_BP < 32'd1) ||
            (V_ACTIVE < 32'd1) || (V_FP < 32'd1) || (V_SYNC < 32'd1) || (V_BP < 32'd1)) begin : g_bad_cfg
            $error("video_timing_gen: every active/porch/sync parameter must be >= 1");
        end
    endgenerate

    vtg_state_e r_state;
    vtg_state_e w_state_nxt;
    logic       w_run_nxt;
    logic       w_adv;
    logic       w_clr;

    logic r_hsync, r_vsync, r_de, r_frame_start, r_frame_end, r_line_start, r_running;

    logic w_h_last, w_h_nxt_active, w_h_nxt_sync, w_h_nxt_zero, w_h_nxt_last;
    logic w_v_last, w_v_nxt_active, w_v_nxt_sync, w_v_nxt_zero, w_v_nxt_last;
    logic w_frame_last;

    assign w_frame_last = w_h_last && w_v_last;

    // Controller next state; the raster only stops after its last pixel.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_run_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) begin
                    w_state_nxt = ST_RUN;
                    w_run_nxt   = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_run_nxt   = 1'b0;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (w_frame_last && !i_enable) begin
                    w_state_nxt = ST_IDLE;
                    w_run_nxt   = 1'b0;
                end else begin
                    w_state_nxt = i_enable ? ST_RUN : ST_DRAIN;
                    w_run_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_run_nxt   = 1'b0;
            end
        endcase
        // Leaving IDLE shows pixel (0,0) first, so counters only step when
        // already running; every non-stepping cycle parks them at 0.
        w_adv = w_run_nxt && (r_state != ST_IDLE);
        w_clr = !w_adv;
    end

    axis_timing_decode #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .LEN    (HLEN)
    ) u_h_axis (
        .clk          (clk),
        .rstn         (rstn),
        .i_clear      (w_clr),
        .i_advance    (w_adv),
        .o_cnt        (o_x),
        .o_last       (w_h_last),
        .o_nxt_active (w_h_nxt_active),
        .o_nxt_sync   (w_h_nxt_sync),
        .o_nxt_zero   (w_h_nxt_zero),
        .o_nxt_last   (w_h_nxt_last)
    );

    axis_timing_decode #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .LEN    (VLEN)
    ) u_v_axis (
        .clk          (clk),
        .rstn         (rstn),
        .i_clear      (w_clr),
        .i_advance    (w_adv && w_h_last),
        .o_cnt        (o_y),
        .o_last       (w_v_last),
        .o_nxt_active (w_v_nxt_active),
        .o_nxt_sync   (w_v_nxt_sync),
        .o_nxt_zero   (w_v_nxt_zero),
        .o_nxt_last   (w_v_nxt_last)
    );

    // State register and registered outputs, decoded from next-pixel values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_line_start  <= 1'b0;
            r_running     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_hsync       <= (w_run_nxt && w_h_nxt_sync) ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= (w_run_nxt && w_v_nxt_sync) ? VSYNC_POL : ~VSYNC_POL;
            r_de          <= w_run_nxt && w_h_nxt_active && w_v_nxt_active;
            r_frame_start <= w_run_nxt && w_h_nxt_zero && w_v_nxt_zero;
            r_frame_end   <= w_run_nxt && w_h_nxt_last && w_v_nxt_last;
            r_line_start  <= w_run_nxt && w_h_nxt_zero;
            r_running     <= w_run_nxt;
        end
    end

    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_de          = r_de;
    assign o_frame_start = r_frame_start;
    assign o_frame_end   = r_frame_end;
    assign o_line_start  = r_line_start;
    assign o_running     = r_running;

endmodule
